instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//   IF stage of the pipelined RV32I core; producer of the IF/ID registers the decode stage consumes (instr, pc).
//   Owns the PC, issues one-outstanding-request fetches to instruction memory, honours decode stall, and
//   squashes/redirects on taken branches/jumps resolved downstream. Inserts NOP bubbles when no instruction is ready.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC loaded on reset
//   NOP_INSTR  32'h0000_0013  bubble encoding (addi x0,x0,0) driven on PIP_instr_o when not valid
// PORTS
//   clk              in   1   clock, all state on rising edge
//   reset_n          in   1   asynchronous, active-low reset
//   id_stall_i       in   1   decode stall: hold IF/ID registers and PC
//   branch_taken_i   in   1   redirect request (taken branch / jump)
//   branch_target_i  in   32  redirect target; bits [1:0] ignored (forced 0)
//   imem_req_o       out  1   fetch request strobe, one cycle per request, accepted unconditionally
//   imem_addr_o      out  32  fetch address (= pc), word aligned
//   imem_rvalid_i    in   1   response strobe, >=1 cycle after request, one per request
//   imem_rdata_i     in   32  instruction word, valid with imem_rvalid_i
//   PIP_instr_o      out  32  IF/ID register: instruction
//   PIP_pc_o         out  32  IF/ID register: PC of that instruction
//   PIP_valid_o      out  1   IF/ID register: 1 = real instruction, 0 = bubble
// BEHAVIOUR
//   Reset (async assert, sync release): pc=RESET_PC, state=S_FETCH, hold_valid=0, PIP_instr_o=NOP_INSTR,
//     PIP_pc_o=0, PIP_valid_o=0, imem_req_o=0 while reset asserted. First request the cycle after release.
//   FSM: S_FETCH  imem_req_o = !branch_taken_i, addr=pc; -> S_WAIT if request sent.
//        S_WAIT   wait imem_rvalid_i. On rvalid: deliver (see below), pc<=pc+4, -> S_FETCH; if stalled -> S_HOLD.
//        S_HOLD   word + its pc parked in hold buffer; stay while id_stall_i; deliver and -> S_FETCH when it drops.
//        S_DROP   outstanding response belongs to squashed path; discard on rvalid, -> S_FETCH.
//   Deliver = IF/ID load {instr,pc,valid=1}; source is imem_rdata_i (S_WAIT) or hold buffer (S_HOLD).
//   IF/ID update priority each cycle: branch_taken_i > id_stall_i > deliver > bubble.
//     redirect: valid<=0, instr<=NOP_INSTR, pc<=0 in IF/ID; fetch pc<={target[31:2],2'b00}; hold_valid<=0.
//     stall: all IF/ID regs and fetch pc hold; a response arriving is parked (S_HOLD), never lost.
//     bubble: valid<=0, instr<=NOP_INSTR, PIP_pc_o holds.
//   Redirect by state: S_FETCH -> request suppressed, stay S_FETCH; S_WAIT w/o rvalid -> S_DROP;
//     S_WAIT with rvalid same cycle -> word discarded, S_FETCH; S_HOLD -> buffer cleared, S_FETCH;
//     S_DROP -> stay S_DROP with new target (still one response outstanding).
//   Redirect + stall same cycle: redirect wins (flush overrides hold).
//   pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). Latency: request->IF/ID valid = memory latency + 1 cycle.
//   Max throughput one instruction per 2 cycles with 1-cycle memory (no request pipelining).
//   Never more than one outstanding request; imem_rvalid_i in S_FETCH is a protocol error ($display, ignored).
// STRUCTURE
//   Shared definitions.vh: NOP_INSTR encoding, RESET_PC default, IF state encodings (S_FETCH/S_WAIT/S_HOLD/S_DROP).
//   Single module; no sub-module (hold buffer is one 64-bit register + flag, kept inline).
// TESTING
//   Reset, 1-cycle memory returning mem[a]=a^32'hA5A5_0000 -> imem_addr_o 0,4,8,...; PIP_pc_o/instr match, valid=1.
//   id_stall_i high 3 cycles while response for pc=8 arrives -> IF/ID frozen at pc=4; pc=8 delivered 1 cycle after release.
//   branch_taken_i, target 32'h100, in S_WAIT (pc=0xC pending, 3-cycle mem) -> 0xC response dropped; next req addr 0x100.
//   Redirect with target 32'h203 -> imem_addr_o=0x200; same-cycle stall+redirect -> valid=0, instr=0x13.
//   RESET_PC=32'hFFFF_FFFC -> fetch 0xFFFF_FFFC then 0x0 (wrap).
//   reset_n low mid S_WAIT -> outputs to reset values immediately; stale rvalid after release ignored, fetch RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the IF stage: bubble encoding, reset PC default,
// fetch FSM states and the parked-word record.
package instruction_fetch_pkg;

    localparam logic [31:0] NOP_ENCODING     = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_DROP
    } if_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_word_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, keeps at most one fetch outstanding, and loads the
// IF/ID registers with fetched words or NOP bubbles.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_ENCODING
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        id_stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] PIP_instr_o,
    output logic [31:0] PIP_pc_o,
    output logic        PIP_valid_o
);

    if_state_e   state, state_next;
    logic [31:0] pc, pc_next;
    fetch_word_t hold, hold_next;
    logic        hold_valid, hold_valid_next;
    logic        req;
    logic        deliver;
    fetch_word_t deliver_word;
    logic [31:0] instr_next;
    logic [31:0] pc_out_next;
    logic        valid_next;

    assign imem_req_o  = req & reset_n;
    assign imem_addr_o = pc;

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        hold_next       = hold;
        hold_valid_next = hold_valid;
        req             = 1'b0;
        deliver         = 1'b0;
        deliver_word    = '{instr: imem_rdata_i, pc: pc};

        unique case (state)
            S_FETCH: begin
                // A response here would be a protocol error; it is ignored.
                req = !branch_taken_i;
                if (!branch_taken_i) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    state_next = S_FETCH;
                    if (!branch_taken_i) begin
                        pc_next = pc + 32'd4;
                        if (id_stall_i) begin
                            state_next      = S_HOLD;
                            hold_next       = '{instr: imem_rdata_i, pc: pc};
                            hold_valid_next = 1'b1;
                        end else begin
                            deliver = 1'b1;
                        end
                    end
                end else if (branch_taken_i) begin
                    state_next = S_DROP;
                end
            end
            S_HOLD: begin
                if (branch_taken_i || !id_stall_i) state_next = S_FETCH;
                if (!branch_taken_i && !id_stall_i) begin
                    deliver         = hold_valid;
                    deliver_word    = hold;
                    hold_valid_next = 1'b0;
                end
            end
            S_DROP: begin
                if (imem_rvalid_i) state_next = S_FETCH;
            end
        endcase

        if (branch_taken_i) begin
            pc_next         = word_align(branch_target_i);
            hold_valid_next = 1'b0;
        end

        // IF/ID priority: redirect, then stall, then deliver, else bubble.
        instr_next  = PIP_instr_o;
        pc_out_next = PIP_pc_o;
        valid_next  = PIP_valid_o;
        if (branch_taken_i) begin
            instr_next  = NOP_INSTR;
            pc_out_next = '0;
            valid_next  = 1'b0;
        end else if (!id_stall_i) begin
            if (deliver) begin
                instr_next  = deliver_word.instr;
                pc_out_next = deliver_word.pc;
                valid_next  = 1'b1;
            end else begin
                instr_next = NOP_INSTR;
                valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            hold        <= '0;
            hold_valid  <= 1'b0;
            PIP_instr_o <= NOP_INSTR;
            PIP_pc_o    <= '0;
            PIP_valid_o <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            hold        <= hold_next;
            hold_valid  <= hold_valid_next;
            PIP_instr_o <= instr_next;
            PIP_pc_o    <= pc_out_next;
            PIP_valid_o <= valid_next;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, multi-cycle corner
// sequences, and randomized traffic checked against an instruction-stream model.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [31:0] tgt = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic [31:0] pip_instr;
    logic [31:0] pip_pc;
    logic        pip_valid;

    logic        rst2_n = 1'b0;
    logic        req2;
    logic [31:0] addr2;
    logic        rv2 = 1'b0;
    logic [31:0] rd2 = '0;
    logic [31:0] pip2_instr;
    logic [31:0] pip2_pc;
    logic        pip2_valid;

    int total = 0;
    int bad   = 0;

    // memory controls
    logic        rst_level = 1'b0;
    logic        mem_flush = 1'b1;
    logic        mem_rand  = 1'b0;
    int          mem_lat   = 1;
    int          cd        = 0;
    logic [31:0] pend      = '0;

    // stream model state
    logic        mon_en  = 1'b0;
    logic [31:0] m_exp   = '0;
    logic        m_br    = 1'b0;
    logic        m_stall = 1'b0;
    logic [31:0] m_tgt   = '0;
    logic        m_valid = 1'b0;
    logic [31:0] m_pc    = '0;
    logic [31:0] m_instr = NOP;
    logic        m_outst = 1'b0;
    int          n_deliv = 0;

    instruction_fetch dut (
        .clk(clk), .reset_n(reset_n), .id_stall_i(stall), .branch_taken_i(br),
        .branch_target_i(tgt), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .PIP_instr_o(pip_instr),
        .PIP_pc_o(pip_pc), .PIP_valid_o(pip_valid)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut_wrap (
        .clk(clk), .reset_n(rst2_n), .id_stall_i(1'b0), .branch_taken_i(1'b0),
        .branch_target_i(32'h0), .imem_req_o(req2), .imem_addr_o(addr2),
        .imem_rvalid_i(rv2), .imem_rdata_i(rd2), .PIP_instr_o(pip2_instr),
        .PIP_pc_o(pip2_pc), .PIP_valid_o(pip2_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    always @(posedge clk) begin
        rv2 <= req2;
        rd2 <= mem_word(addr2);
    end

    // Main memory: latch request on the falling edge, answer after cd cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (imem_req && reset_n && !mem_flush) begin
                pend = imem_addr;
                cd   = mem_rand ? int'($urandom_range(3, 1)) : mem_lat;
            end
            @(posedge clk);
            #1;
            rvalid = 1'b0;
            if (mem_flush) cd = 0;
            else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    rvalid = 1'b1;
                    rdata  = mem_word(pend);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Instruction-stream model: program order, flush/hold/bubble rules, request protocol.
    task automatic model_step();
        if (!reset_n) begin
            m_exp = 32'h0; m_br = 1'b0; m_stall = 1'b0; m_outst = 1'b0;
        end else begin
            if (m_br) begin
                chk("flush_valid", pip_valid, 0);
                chk("flush_instr", pip_instr, NOP);
                chk("flush_pc", pip_pc, 0);
                m_exp = m_tgt & ~32'd3;
            end else if (m_stall) begin
                chk("stall_valid", pip_valid, m_valid);
                chk("stall_pc", pip_pc, m_pc);
                chk("stall_instr", pip_instr, m_instr);
            end else if (pip_valid) begin
                chk("deliver_pc", pip_pc, m_exp);
                chk("deliver_instr", pip_instr, mem_word(m_exp));
                m_exp = m_exp + 32'd4;
                n_deliv++;
            end else begin
                chk("bubble_instr", pip_instr, NOP);
                chk("bubble_pc", pip_pc, m_pc);
            end
            if (br) chk("req_suppressed", imem_req, 0);
            if (imem_req) begin
                chk("req_addr", imem_addr, m_exp);
                chk("req_single_outstanding", m_outst | rvalid, 0);
            end
            if (rvalid) m_outst = 1'b0;
            if (imem_req) m_outst = 1'b1;
        end
        m_br = br; m_stall = stall; m_tgt = tgt;
        m_valid = pip_valid; m_pc = pip_pc; m_instr = pip_instr;
    endtask

    task automatic cycle(input logic s, input logic b, input logic [31:0] t);
        @(posedge clk);
        #1;
        reset_n = rst_level;
        stall = s; br = b; tgt = t;
        @(negedge clk);
        if (mon_en) model_step();
    endtask

    task automatic do_reset();
        rst_level = 1'b0;
        mem_flush = 1'b1;
        repeat (3) cycle(0, 0, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_valid", pip_valid, 0);
        chk("rst_instr", pip_instr, NOP);
        chk("rst_pc", pip_pc, 0);
        rst_level = 1'b1;
        mem_flush = 1'b0;
    endtask

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } vec_t;

    vec_t        tbl[16];
    logic        found, saw_c, saw_100, got;
    int          n, nreq;
    logic [31:0] waddr[2];
    logic [31:0] wpc, winstr;

    initial begin
        // stall, br, tgt | req, addr, valid, pc, instr  (1-cycle memory, cycle 0 = reset release)
        tbl[0]  = '{0, 0, 32'h0,   1, 32'h0,   0, 32'h0,  NOP};
        tbl[1]  = '{0, 0, 32'h0,   0, 32'h0,   0, 32'h0,  NOP};
        tbl[2]  = '{0, 0, 32'h0,   1, 32'h4,   1, 32'h0,  32'hA5A5_0000};
        tbl[3]  = '{0, 0, 32'h0,   0, 32'h4,   0, 32'h0,  NOP};
        tbl[4]  = '{1, 0, 32'h0,   1, 32'h8,   1, 32'h4,  32'hA5A5_0004};
        tbl[5]  = '{1, 0, 32'h0,   0, 32'h8,   1, 32'h4,  32'hA5A5_0004};
        tbl[6]  = '{1, 0, 32'h0,   0, 32'hC,   1, 32'h4,  32'hA5A5_0004};
        tbl[7]  = '{0, 0, 32'h0,   0, 32'hC,   1, 32'h4,  32'hA5A5_0004};
        tbl[8]  = '{0, 0, 32'h0,   1, 32'hC,   1, 32'h8,  32'hA5A5_0008};
        tbl[9]  = '{0, 1, 32'h203, 0, 32'hC,   0, 32'h8,  NOP};
        tbl[10] = '{0, 0, 32'h0,   1, 32'h200, 0, 32'h0,  NOP};
        tbl[11] = '{1, 1, 32'h40,  0, 32'h200, 0, 32'h0,  NOP};
        tbl[12] = '{0, 0, 32'h0,   1, 32'h40,  0, 32'h0,  NOP};
        tbl[13] = '{0, 0, 32'h0,   0, 32'h40,  0, 32'h0,  NOP};
        tbl[14] = '{1, 1, 32'h80,  0, 32'h44,  1, 32'h40, 32'hA5A5_0040};
        tbl[15] = '{0, 0, 32'h0,   1, 32'h80,  0, 32'h0,  NOP};

        mon_en = 1'b1;
        mem_rand = 1'b0;
        mem_lat = 1;
        do_reset();
        for (int unsigned i = 0; i < 16; i++) begin
            cycle(tbl[i].stall, tbl[i].br, tbl[i].tgt);
            chk($sformatf("vec%0d_req", i), imem_req, tbl[i].req);
            chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("vec%0d_valid", i), pip_valid, tbl[i].valid);
            chk($sformatf("vec%0d_pc", i), pip_pc, tbl[i].pc);
            chk($sformatf("vec%0d_instr", i), pip_instr, tbl[i].instr);
        end

        // Redirect while a 3-cycle fetch of 0xC is outstanding.
        mem_lat = 3;
        do_reset();
        found = 1'b0; n = 0; saw_c = 1'b0; saw_100 = 1'b0;
        while (!found && n < 40) begin
            cycle(0, 0, 0);
            n++;
            if (imem_req && imem_addr == 32'hC) found = 1'b1;
        end
        chk("drop_setup_req_c", found, 1);
        cycle(0, 1, 32'h100);
        found = 1'b0; n = 1;
        while (!found && n < 20) begin
            cycle(0, 0, 0);
            n++;
            if (pip_valid && pip_pc == 32'hC) saw_c = 1'b1;
            if (imem_req) found = 1'b1;
        end
        chk("drop_next_req_seen", found, 1);
        chk("drop_next_req_cycle", n, 4);
        chk("drop_next_req_addr", imem_addr, 32'h100);
        repeat (8) begin
            cycle(0, 0, 0);
            if (pip_valid && pip_pc == 32'hC) saw_c = 1'b1;
            if (pip_valid && pip_pc == 32'h100) saw_100 = 1'b1;
        end
        chk("drop_word_discarded", saw_c, 0);
        chk("drop_target_delivered", saw_100, 1);

        // Randomized traffic against the stream model.
        mem_rand = 1'b1;
        do_reset();
        n_deliv = 0;
        for (int unsigned i = 0; i < 1500; i++) begin
            cycle(($urandom % 4) == 0, ($urandom % 12) == 0, $urandom & 32'h0000_0FFF);
        end
        chk("rand_progress", n_deliv >= 100, 1);

        // Reset mid-fetch; the stale response lands in the release cycle.
        mem_rand = 1'b0;
        mem_lat = 3;
        do_reset();
        mon_en = 1'b0;
        found = 1'b0; n = 0;
        while (!found && n < 40) begin
            cycle(0, 0, 0);
            n++;
            if (imem_req && imem_addr == 32'h8) found = 1'b1;
        end
        chk("stale_setup_req_8", found, 1);
        chk("stale_setup_pc", pip_pc, 32'h4);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        rst_level = 1'b0;
        #1;
        chk("async_rst_valid", pip_valid, 0);
        chk("async_rst_instr", pip_instr, NOP);
        chk("async_rst_pc", pip_pc, 0);
        chk("async_rst_req", imem_req, 0);
        cycle(0, 0, 0);
        rst_level = 1'b1;
        cycle(0, 0, 0);
        chk("stale_release_req", imem_req, 1);
        chk("stale_release_addr", imem_addr, 32'h0);
        got = 1'b0; n = 0;
        while (!got && n < 12) begin
            cycle(0, 0, 0);
            n++;
            if (pip_valid) got = 1'b1;
        end
        chk("stale_first_delivery", got, 1);
        chk("stale_first_pc", pip_pc, 32'h0);
        chk("stale_first_instr", pip_instr, mem_word(32'h0));

        // Wrap-around from RESET_PC = 0xFFFF_FFFC.
        chk("wrap_in_reset_req", req2, 0);
        @(negedge clk);
        rst2_n = 1'b1;
        nreq = 0; got = 1'b0; wpc = '0; winstr = '0;
        waddr[0] = '0; waddr[1] = '0;
        #1;
        if (req2) begin
            waddr[0] = addr2;
            nreq = 1;
        end
        for (int unsigned i = 0; i < 20; i++) begin
            cycle(0, 0, 0);
            if (req2 && nreq < 2) begin
                waddr[nreq] = addr2;
                nreq++;
            end
            if (pip2_valid && !got) begin
                got = 1'b1;
                wpc = pip2_pc;
                winstr = pip2_instr;
            end
        end
        chk("wrap_req_count", nreq, 2);
        chk("wrap_first_addr", waddr[0], 32'hFFFF_FFFC);
        chk("wrap_second_addr", waddr[1], 32'h0);
        chk("wrap_delivered", got, 1);
        chk("wrap_delivered_pc", wpc, 32'hFFFF_FFFC);
        chk("wrap_delivered_instr", winstr, mem_word(32'hFFFF_FFFC));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
